// File: rtl/mem_wb_regfile_pkg.sv
// mem_wb_regfile_pkg: shared widths, enable levels, zero constants and stall-bit indices
package mem_wb_regfile_pkg;
  localparam int RegNum = 32;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable = 1'b1;
  localparam logic ReadDisable = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;
endpackage

// File: rtl/mem_wb_regfile_regfile.sv
// mem_wb_regfile_regfile: register array with one write port (we/waddr/wdata) and two bypassed combinational read ports (re/raddr -> rdata)
module mem_wb_regfile_regfile
  import mem_wb_regfile_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int REG_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [REG_W-1:0]  rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [REG_W-1:0]  rdata2
);
  logic [REG_W-1:0] regs [REG_NUM];
  always_ff @(posedge clk)
    if (rst == RstEnable) regs <= '{default: '0};
    else if (we == WriteEnable && waddr != NOPRegAddr) regs[waddr] <= wdata;
  always_comb begin
    rdata1 = (rst == RstEnable || re1 == ReadDisable || raddr1 == NOPRegAddr) ? '0 :
             (we == WriteEnable && raddr1 == waddr) ? wdata : regs[raddr1];
    rdata2 = (rst == RstEnable || re2 == ReadDisable || raddr2 == NOPRegAddr) ? '0 :
             (we == WriteEnable && raddr2 == waddr) ? wdata : regs[raddr2];
  end
endmodule

// File: rtl/mem_wb_regfile.sv
// mem_wb_regfile: MEM/WB pipeline register (mem_* in, wb_* out, stall/flush control) feeding the register file with read ports re/raddr/rdata 1 and 2
module mem_wb_regfile
  import mem_wb_regfile_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int REG_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [REG_W-1:0]  mem_wdata,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [REG_W-1:0]  wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [REG_W-1:0]  rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [REG_W-1:0]  rdata2
);
  logic unused_stall;
  assign unused_stall = ^stall[3:0];
  always_ff @(posedge clk)
    if (rst == RstEnable || flush || (stall[STALL_MEM] && !stall[STALL_WB])) begin
      wb_wd <= '0;
      wb_wreg <= WriteDisable;
      wb_wdata <= '0;
    end else if (!stall[STALL_MEM]) begin
      wb_wd <= mem_wd;
      wb_wreg <= mem_wreg;
      wb_wdata <= mem_wdata;
    end
  mem_wb_regfile_regfile #(.REG_NUM(REG_NUM), .REG_W(REG_W), .ADDR_W(ADDR_W)) u_regfile (
    .clk(clk), .rst(rst), .we(wb_wreg), .waddr(wb_wd), .wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );
endmodule

// File: tb/tb_mem_wb_regfile.sv
// tb_mem_wb_regfile: directed bench with a per-cycle reference model and literal spot checks
module tb_mem_wb_regfile;
  logic clk = 0, rst = 1, flush = 0, mem_wreg = 0, re1 = 0, re2 = 0;
  logic [5:0] stall = '0;
  logic [4:0] mem_wd = '0, raddr1 = '0, raddr2 = '0;
  logic [31:0] mem_wdata = '0;
  logic [4:0] wb_wd;
  logic wb_wreg;
  logic [31:0] wb_wdata, rdata1, rdata2;
  int tests = 0, fails = 0;
  logic [31:0] m_regs [32];
  logic [4:0] m_wd;
  logic m_wreg;
  logic [31:0] m_wdata;
  bit started = 0;
  mem_wb_regfile dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
    if (rst || !re || a == 0) return 0;
    if (m_wreg && a == m_wd) return m_wdata;
    return m_regs[a];
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      {m_wd, m_wreg, m_wdata} = '0;
      started = 1;
    end else begin
      if (m_wreg && m_wd != 0) m_regs[m_wd] = m_wdata;
      if (flush || (stall[4] && !stall[5])) {m_wd, m_wreg, m_wdata} = '0;
      else if (!stall[4]) {m_wd, m_wreg, m_wdata} = {mem_wd, mem_wreg, mem_wdata};
    end
  end
  always @(negedge clk)
    if (started) begin
      chk("model_wb_wd", 32'(wb_wd), 32'(m_wd));
      chk("model_wb_wreg", 32'(wb_wreg), 32'(m_wreg));
      chk("model_wb_wdata", wb_wdata, m_wdata);
      chk("model_rdata1", rdata1, m_read(re1, raddr1));
      chk("model_rdata2", rdata2, m_read(re2, raddr2));
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mem(input logic [4:0] wd, input logic we, input logic [31:0] d);
    mem_wd = wd;
    mem_wreg = we;
    mem_wdata = d;
  endtask
  initial begin
    re1 = 1;
    raddr1 = 7;
    cyc();
    cyc();
    #1 chk("rst_rdata1", rdata1, 0);
    rst = 0;
    cyc();
    chk("rel_wb_wreg", 32'(wb_wreg), 0);
    chk("rel_rdata1_a7", rdata1, 0);
    mem(5, 1, 32'hDEADBEEF);
    cyc();
    mem(0, 0, 0);
    raddr1 = 5;
    #1 chk("wr_wb_wdata", wb_wdata, 32'hDEADBEEF);
    chk("wr_bypass_rdata1", rdata1, 32'hDEADBEEF);
    cyc();
    re2 = 1;
    raddr2 = 5;
    #1 chk("wr_array_rdata2", rdata2, 32'hDEADBEEF);
    chk("wr_wb_wreg_idle", 32'(wb_wreg), 0);
    mem(0, 1, 32'hFFFFFFFF);
    cyc();
    mem(0, 0, 0);
    raddr1 = 0;
    #1 chk("r0_wb_wreg", 32'(wb_wreg), 1);
    chk("r0_bypass_rdata1", rdata1, 0);
    cyc();
    chk("r0_commit_rdata1", rdata1, 0);
    mem(3, 1, 32'h11);
    cyc();
    stall = 6'b110000;
    mem(3, 1, 32'h99);
    raddr2 = 3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_wb_wd", 32'(wb_wd), 3);
      chk("hold_wb_wdata", wb_wdata, 32'h11);
      chk("hold_rdata2", rdata2, 32'h11);
    end
    stall = 6'b010000;
    mem(3, 1, 32'h22);
    cyc();
    chk("bubble_wb_wreg", 32'(wb_wreg), 0);
    chk("bubble_wb_wdata", wb_wdata, 0);
    stall = 0;
    mem(0, 0, 0);
    cyc();
    chk("bubble_reg3", rdata2, 32'h11);
    mem(6, 1, 32'h66);
    cyc();
    flush = 1;
    stall = 6'b110000;
    cyc();
    flush = 0;
    stall = 0;
    mem(0, 0, 0);
    raddr1 = 6;
    #1 chk("flush_wb_wreg", 32'(wb_wreg), 0);
    chk("flush_wb_wd", 32'(wb_wd), 0);
    chk("flush_reg6", rdata1, 32'h66);
    mem(10, 1, 32'hABCD);
    cyc();
    mem(0, 0, 0);
    raddr1 = 10;
    raddr2 = 10;
    #1 chk("same_addr_rdata1", rdata1, 32'hABCD);
    chk("same_addr_rdata2", rdata2, 32'hABCD);
    re1 = 0;
    #1 chk("re_off_rdata1", rdata1, 0);
    re1 = 1;
    mem(9, 1, 32'h1234);
    cyc();
    mem(0, 0, 0);
    #1 chk("mid_wb_wd", 32'(wb_wd), 9);
    rst = 1;
    cyc();
    rst = 0;
    cyc();
    raddr1 = 9;
    raddr2 = 10;
    #1 chk("mid_reg9", rdata1, 0);
    chk("mid_reg10", rdata2, 0);
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_wb_regfile.md
Name: mem_wb_regfile

Overview:
- Write-back stage of the five-stage pipeline.
- Latches the memory-stage result (destination address, write enable, write data) into the MEM/WB pipeline register, then commits it to the 32x32 general-purpose register file on the next edge.
- Provides the two combinational read ports used by decode, with write-through bypass, so decode sees a value in the same cycle it is being written back.

Parameters:
- REG_NUM, 32, number of general-purpose registers (register 0 hardwired to zero).
- REG_W, 32, data width of each register (RegBus).
- ADDR_W, 5, register address width (RegAddrBus); must equal log2(REG_NUM).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  6  pipeline stall vector from control; bit4 = MEM stage stalled, bit5 = WB stage stalled.
- flush  in  1  pipeline flush; inserts a bubble into MEM/WB.
- mem_wd  in  ADDR_W  destination register address from the memory stage.
- mem_wreg  in  1  write enable from the memory stage.
- mem_wdata  in  REG_W  write data from the memory stage.
- wb_wd  out  ADDR_W  latched destination address (also used by forwarding logic).
- wb_wreg  out  1  latched write enable.
- wb_wdata  out  REG_W  latched write data.
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  REG_W  read data, port 1 (combinational).
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  REG_W  read data, port 2 (combinational).

Behaviour:
- Reset, at the clk edge with rst=1:
  - wb_wd=0, wb_wreg=0, wb_wdata=0.
  - All REG_NUM registers cleared to 0; no write occurs that edge.
  - While rst=1, rdata1=rdata2=0.
- MEM/WB register update, per edge with rst=0, priority order:
  1. flush=1: load bubble (wd=0, wreg=0, wdata=0).
  2. stall[4]=1 and stall[5]=0: load bubble.
  3. stall[4]=1 and stall[5]=1: hold current contents.
  4. Otherwise: load mem_wd/mem_wreg/mem_wdata.
- Register-file write:
  - At each edge with rst=0, if wb_wreg=1 and wb_wd!=0, reg[wb_wd] <= wb_wdata.
  - The write uses the pre-edge latched values.
  - Latency: mem input at edge N appears in wb_* after edge N and is committed to the array at edge N+1.
  - A write to register 0 is discarded.
- Read ports are combinational and identical; port k behaves as follows:
  - reek=0 -> 0.
  - raddrk=0 -> 0.
  - Bypass: reek=1 and raddrk==wb_wd and wb_wreg=1 -> wb_wdata.
  - Otherwise -> reg[raddrk].
- Simultaneous events:
  - Both ports may read the same address, including the address being bypassed; both return the same value.
  - flush overrides stall.
  - A held (stalled) entry with wreg=1 is rewritten each held cycle with the same data; this is harmless and idempotent.
- Reset mid-operation: a pending wb_* write is discarded, not committed.
- Width rules:
  - No arithmetic in this block.
  - Addresses are exact width; no wrap-around is possible.

Decomposition:
- Shared defines package:
  - RstEnable, WriteEnable/WriteDisable, ReadEnable/ReadDisable.
  - ZeroWord, NOPRegAddr, RegBus, RegAddrBus, RegNum.
  - Stall-bit indices STALL_MEM=4, STALL_WB=5.
- One sub-module, regfile:
  - Contains the array, the write port, and both bypassed read ports.
  - Top level holds only the MEM/WB register and the stall/flush priority logic.

Test Plan:
- Reset release: hold rst=1 for 2 cycles, then rst=0 -> wb_wreg=0; re1=1, raddr1=7 gives rdata1=0.
- Write then read: mem_wd=5, wreg=1, wdata=0xDEADBEEF for one cycle. After edge 1, wb_wdata=0xDEADBEEF and rdata1(addr5)=0xDEADBEEF via bypass. After edge 2, with mem inputs idle, rdata2(addr5)=0xDEADBEEF from the array.
- Register 0: write addr0 with 0xFFFFFFFF -> rdata1(addr0)=0 both during bypass and after commit.
- Stall hold vs bubble:
  - stall=6'b110000 with wb holding addr3/0x11 -> wb_* unchanged over 3 cycles; reg3=0x11.
  - stall=6'b010000 -> wb_wreg=0 next cycle, and mem data 0x22 for addr3 is not latched.
- Flush priority: flush=1 together with stall=6'b110000 -> wb_wreg=0, wb_wd=0 next edge.
- Reset mid-flight: latch addr9/0x1234 into wb, assert rst on the next edge -> reg9 reads 0 after rst drops.
